board_input_fsm: RTL and testbench
==================================

# board_input_fsm

Parametrised user-input controller for the chess board datapath: turns five push-button inputs into cursor movement, piece selection and move commits for an N×N board. Commits are issued as a two-write sequence to the board storage: place the piece at the destination, then clear the source. It adds several features over the fixed 8×8 controller:
- rising-edge button detection
- selection cancel and re-select
- optional cursor wrap
- per-turn timeout
- move counter

It sits between the debounced buttons, the move-legality checker (which supplies `allow_move`) and the board builder / VGA renderer.

## Interface
Parameters:
- `BOARD_DIM`, default 8: squares per side; must be a power of two ≥2. `CW` = log2(`BOARD_DIM`); `AW` = 2·`CW`.
- `PIECE_W`, default 4: bits per square. The MSB is colour (0 = white, 1 = black). The low `PIECE_W`-1 bits are the piece type; type 0 means empty.
- `CURSOR_INIT`, default 38: cursor index after reset.
- `WRAP`, default 0: 0 = cursor saturates at board edges; 1 = cursor wraps modulo `BOARD_DIM`.
- `TURN_TIMEOUT`, default 0: cycles allowed per turn; 0 disables the timeout.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `allow_move` in 1: legality verdict for (`sel_loc` → `cursor`); valid in the same cycle as the `btn_c` edge.
- `board` in `BOARD_DIM`²·`PIECE_W`: square i occupies `board[i*PIECE_W +: PIECE_W]`.
- `btn_c`, `btn_u`, `btn_d`, `btn_r`, `btn_l` in 1 each: debounced button levels.
- `write_en` out 1: board write strobe.
- `write_addr` out `AW`: square index to write.
- `write_data` out `PIECE_W`: value to write.
- `move_data` out 2·`AW`+2: {`turn`, `sel_valid`, `sel_loc`, `cursor`}.
- `state` out 3: current FSM state.
- `move_count` out 16: completed moves, wraps modulo 2^16.
- `timeout` out 1: one-cycle pulse when a turn expires.

## Operation
Square indexing:
- Square index = {col, row}, with col in bits [`AW`-1:`CW`] and row in bits [`CW`-1:0].

Buttons and cursor:
- Each button is registered; an event is `btn & ~btn_q`. The `btn_q` registers reset to 1, so a button held through reset produces no event.
- Cursor moves at most one step per cycle. Priority is L > R > D > U:
  - L: col−1
  - R: col+1
  - D: row+1
  - U: row−1
- At an edge with `WRAP`=0 the cursor does not move; with `WRAP`=1 it wraps to the opposite edge.
- The cursor moves in every state; it does not move in the reset cycle.

FSM states and transitions:
- START (0): go to SELECT after one cycle. Clear the turn timer.
- SELECT (1): on a C event, if the cursor square is non-empty and its colour equals `turn`: latch `sel_loc` = `cursor`, set `sel_valid`=1, go to MOVE. Otherwise stay in SELECT.
- MOVE (2): on a C event, evaluate the cases in this order:
  - `cursor` == `sel_loc`: cancel. Clear `sel_valid`, go to SELECT.
  - `allow_move`=1: latch the destination = `cursor`, go to PLACE with `write_en`=1, `write_addr`=dest, `write_data`=`board[sel_loc]`.
  - Cursor square holds a piece of colour `turn`: re-select. `sel_loc` = `cursor`, stay in MOVE.
  - Otherwise: clear `sel_valid`, go to SELECT.
- PLACE (3): set `write_addr`=`sel_loc`, `write_data`=0, keep `write_en`=1, clear `sel_valid`, go to REMOVE.
- REMOVE (4): set `write_en`=0, toggle `turn`, increment `move_count`, clear the turn timer, go to SELECT.

Turn timeout (`TURN_TIMEOUT`>0):
- The timer increments on each cycle spent in SELECT or MOVE.
- When the timer reaches `TURN_TIMEOUT`-1 and no commit happens in that cycle:
  - pulse `timeout`
  - toggle `turn`
  - clear `sel_valid` and the timer
  - go to SELECT; `move_count` is unchanged.
- A commit (MOVE→PLACE) in the expiry cycle takes precedence over the timeout.
- A C event in SELECT in the expiry cycle is discarded.

Reset values:
- `state`=START, `turn`=0, `cursor`=`CURSOR_INIT`
- `sel_valid`=0, `sel_loc`=0
- `write_en`=0, `write_addr`=0, `write_data`=0
- `move_count`=0, `timeout`=0, timer=0

## Timing
- All outputs are registered. `move_data` is a concatenation of registers.
- Cursor update appears 1 cycle after the button rising edge (2 cycles after the raw level rises, because of the `btn_q` register).
- Commit sequence, where cycle k is the cycle in which the C event is seen in MOVE:
  - cycle k+1: place write visible (state PLACE).
  - cycle k+2: clear write visible (state REMOVE).
  - cycle k+3: `write_en`=0; `turn` and `move_count` are updated.
- `allow_move` and `board` are sampled only in the event cycle. They may change afterwards; the piece value is latched into `write_data` at k+1.
- Reset in any cycle, including PLACE or REMOVE: the next cycle shows the reset values. There is no pending write, no turn toggle and no count increment.

## Test plan
- Commit: reset; `board[38]`=4'b0001; C → state MOVE, `sel_loc`=38; U,U → cursor 36; `allow_move`=1, C → `write_en`=1 with (36, 0001), then (38, 0000), then `write_en`=0, `turn`=1, `move_count`=1.
- Edge detection and priority: hold L for 10 cycles → cursor 38→30 exactly once; press L and U in the same cycle → only col−1 occurs.
- Edges: cursor at 0, press L → stays 0 (`WRAP`=0) or becomes 56 (`WRAP`=1); cursor at 63, press D → stays 63 or becomes 56.
- Cancel and re-select: select 38, C at 38 → SELECT, `sel_valid`=0, no write. Select 38, move to an own piece at 46, `allow_move`=0, C → MOVE, `sel_loc`=46. Press C on a black piece → SELECT.
- Timeout: `TURN_TIMEOUT`=100, no input → `timeout` pulses on the 100th SELECT cycle, `turn`=1, `move_count`=0.
- Mid-operation reset: assert `reset` in the PLACE cycle → next cycle `write_en`=0, state START, `turn`=0, and no clear write ever issued.

Source files
------------

// File: rtl/board_input_fsm.sv
// Push-button controller for an N x N chess board: moves the cursor, selects pieces
// and commits moves as a place-then-clear write pair, with optional wrap and turn timeout.
module board_input_fsm #(
    parameter int BOARD_DIM    = 8,
    parameter int PIECE_W      = 4,
    parameter int CURSOR_INIT  = 38,
    parameter int WRAP         = 0,
    parameter int TURN_TIMEOUT = 0,
    localparam int CW = $clog2(BOARD_DIM),
    localparam int AW = 2 * CW
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   allow_move,
    input  logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] board,
    input  logic                                   btn_c,
    input  logic                                   btn_u,
    input  logic                                   btn_d,
    input  logic                                   btn_r,
    input  logic                                   btn_l,
    output logic                                   write_en,
    output logic [AW-1:0]                          write_addr,
    output logic [PIECE_W-1:0]                     write_data,
    output logic [2*AW+1:0]                        move_data,
    output logic [2:0]                             state,
    output logic [15:0]                            move_count,
    output logic                                   timeout
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_SELECT = 3'd1,
        ST_MOVE   = 3'd2,
        ST_PLACE  = 3'd3,
        ST_REMOVE = 3'd4
    } state_t;

    localparam bit            WRAP_EN    = (WRAP != 0);
    localparam bit            TIMER_EN   = (TURN_TIMEOUT > 0);
    localparam logic [31:0]   TIMER_LAST = TIMER_EN ? 32'(TURN_TIMEOUT - 1) : 32'd0;
    localparam logic [AW-1:0] CURSOR_RST = AW'(CURSOR_INIT);
    localparam logic [CW-1:0] EDGE_MAX   = '1;

    // Button vector order: 0 = L, 1 = R, 2 = D, 3 = U, 4 = C
    localparam int B_L = 0;
    localparam int B_R = 1;
    localparam int B_D = 2;
    localparam int B_U = 3;
    localparam int B_C = 4;

    state_t cur_state, next_state;

    logic [4:0]         btn_in, btn_s, btn_q, ev;
    logic [AW-1:0]      cursor, cursor_nxt;
    logic [AW-1:0]      sel_loc, sel_loc_nxt;
    logic               sel_valid, sel_valid_nxt;
    logic               turn, turn_nxt;
    logic               write_en_nxt;
    logic [AW-1:0]      write_addr_nxt;
    logic [PIECE_W-1:0] write_data_nxt;
    logic [15:0]        move_count_nxt;
    logic               timeout_nxt;
    logic [31:0]        timer, timer_nxt;

    logic [CW-1:0]      col, row, col_nxt, row_nxt;
    logic [PIECE_W-1:0] cur_piece, sel_piece;
    logic               own_piece, expire, commit;

    assign btn_in = {btn_c, btn_u, btn_d, btn_r, btn_l};
    assign ev     = btn_s & ~btn_q;

    assign col = cursor[AW-1:CW];
    assign row = cursor[CW-1:0];

    assign cur_piece = board[int'(cursor) * PIECE_W +: PIECE_W];
    assign sel_piece = board[int'(sel_loc) * PIECE_W +: PIECE_W];
    assign own_piece = (cur_piece[PIECE_W-2:0] != '0) && (cur_piece[PIECE_W-1] == turn);

    assign expire = TIMER_EN && (timer == TIMER_LAST) &&
                    ((cur_state == ST_SELECT) || (cur_state == ST_MOVE));
    assign commit = (cur_state == ST_MOVE) && ev[B_C] && (cursor != sel_loc) && allow_move;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= ST_START;
        else       cur_state <= next_state;
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_START:  next_state = ST_SELECT;
            ST_SELECT: if (!expire && ev[B_C] && own_piece) next_state = ST_MOVE;
            ST_MOVE: begin
                if (commit)                   next_state = ST_PLACE;
                else if (expire)              next_state = ST_SELECT;
                else if (ev[B_C]) begin
                    if (cursor == sel_loc)    next_state = ST_SELECT;
                    else if (own_piece)       next_state = ST_MOVE;
                    else                      next_state = ST_SELECT;
                end
            end
            ST_PLACE:  next_state = ST_REMOVE;
            ST_REMOVE: next_state = ST_SELECT;
            default:   next_state = ST_START;
        endcase
    end

    // Cursor: one step per cycle, priority L > R > D > U, saturate or wrap at edges
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (ev[B_L]) begin
            if (col != '0 || WRAP_EN) col_nxt = col - 1'b1;
        end else if (ev[B_R]) begin
            if (col != EDGE_MAX || WRAP_EN) col_nxt = col + 1'b1;
        end else if (ev[B_D]) begin
            if (row != EDGE_MAX || WRAP_EN) row_nxt = row + 1'b1;
        end else if (ev[B_U]) begin
            if (row != '0 || WRAP_EN) row_nxt = row - 1'b1;
        end
        cursor_nxt = {col_nxt, row_nxt};
    end

    always_comb begin
        turn_nxt       = turn;
        sel_valid_nxt  = sel_valid;
        sel_loc_nxt    = sel_loc;
        write_en_nxt   = write_en;
        write_addr_nxt = write_addr;
        write_data_nxt = write_data;
        move_count_nxt = move_count;
        timeout_nxt    = 1'b0;
        timer_nxt      = timer;
        case (cur_state)
            ST_START: timer_nxt = '0;
            ST_SELECT: begin
                if (expire) begin
                    timeout_nxt   = 1'b1;
                    turn_nxt      = ~turn;
                    sel_valid_nxt = 1'b0;
                    timer_nxt     = '0;
                end else begin
                    timer_nxt = timer + 32'd1;
                    if (ev[B_C] && own_piece) begin
                        sel_loc_nxt   = cursor;
                        sel_valid_nxt = 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                timer_nxt = timer + 32'd1;
                if (commit) begin
                    write_en_nxt   = 1'b1;
                    write_addr_nxt = cursor;
                    write_data_nxt = sel_piece;
                end else if (expire) begin
                    timeout_nxt   = 1'b1;
                    turn_nxt      = ~turn;
                    sel_valid_nxt = 1'b0;
                    timer_nxt     = '0;
                end else if (ev[B_C]) begin
                    if (cursor != sel_loc && own_piece) sel_loc_nxt   = cursor;
                    else                                sel_valid_nxt = 1'b0;
                end
            end
            ST_PLACE: begin
                write_en_nxt   = 1'b1;
                write_addr_nxt = sel_loc;
                write_data_nxt = '0;
                sel_valid_nxt  = 1'b0;
            end
            ST_REMOVE: begin
                write_en_nxt   = 1'b0;
                turn_nxt       = ~turn;
                move_count_nxt = move_count + 16'd1;
                timer_nxt      = '0;
            end
            default: ;
        endcase
    end

    // Button history resets high so a button held through reset yields no event
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s      <= '1;
            btn_q      <= '1;
            cursor     <= CURSOR_RST;
            turn       <= 1'b0;
            sel_valid  <= 1'b0;
            sel_loc    <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            move_count <= '0;
            timeout    <= 1'b0;
            timer      <= '0;
        end else begin
            btn_s      <= btn_in;
            btn_q      <= btn_s;
            cursor     <= cursor_nxt;
            turn       <= turn_nxt;
            sel_valid  <= sel_valid_nxt;
            sel_loc    <= sel_loc_nxt;
            write_en   <= write_en_nxt;
            write_addr <= write_addr_nxt;
            write_data <= write_data_nxt;
            move_count <= move_count_nxt;
            timeout    <= timeout_nxt;
            timer      <= timer_nxt;
        end
    end

    assign state     = cur_state;
    assign move_data = {turn, sel_valid, sel_loc, cursor};

endmodule

// File: tb/tb_board_input_fsm.sv
// Directed bench for board_input_fsm: a saturating instance for the main flow and a
// wrapping instance with a 100-cycle turn timeout.
module tb_board_input_fsm;

    localparam int L = 0;
    localparam int R = 1;
    localparam int D = 2;
    localparam int U = 3;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_a, rst_b;
    logic         allow_move;
    logic [255:0] board;
    logic         btn_c, btn_u, btn_d, btn_r, btn_l;

    logic         we_a, we_b;
    logic [5:0]   addr_a, addr_b;
    logic [3:0]   data_a, data_b;
    logic [13:0]  md_a, md_b;
    logic [2:0]   st_a, st_b;
    logic [15:0]  cnt_a, cnt_b;
    logic         to_a, to_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_input_fsm dut_a (
        .clk(clk), .reset(rst_a), .allow_move(allow_move), .board(board),
        .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_r(btn_r), .btn_l(btn_l),
        .write_en(we_a), .write_addr(addr_a), .write_data(data_a), .move_data(md_a),
        .state(st_a), .move_count(cnt_a), .timeout(to_a)
    );

    board_input_fsm #(.WRAP(1), .TURN_TIMEOUT(100)) dut_b (
        .clk(clk), .reset(rst_b), .allow_move(1'b0), .board(board),
        .btn_c(1'b0), .btn_u(btn_u), .btn_d(btn_d), .btn_r(btn_r), .btn_l(btn_l),
        .write_en(we_b), .write_addr(addr_b), .write_data(data_b), .move_data(md_b),
        .state(st_b), .move_count(cnt_b), .timeout(to_b)
    );

    logic [5:0] cur_a, cur_b, sel_a;
    logic       selv_a, turn_a, turn_b;
    assign cur_a  = md_a[5:0];
    assign sel_a  = md_a[11:6];
    assign selv_a = md_a[12];
    assign turn_a = md_a[13];
    assign cur_b  = md_b[5:0];
    assign turn_b = md_b[13];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            L: btn_l = val;
            R: btn_r = val;
            D: btn_d = val;
            U: btn_u = val;
            default: btn_c = val;
        endcase
    endtask

    // Rise, let the event register, then release fully so the next press is a fresh edge
    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick();
        tick();
        set_btn(which, 1'b0);
        tick();
        tick();
    endtask

    task automatic set_square(input int idx, input logic [3:0] val);
        board[idx*4 +: 4] = val;
    endtask

    task automatic reset_both();
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; allow_move = 1'b0; board = '0;
        btn_c = 1'b0; btn_u = 1'b0; btn_d = 1'b0; btn_r = 1'b0; btn_l = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_state",  st_a,   3'd0);
        check("rst_cursor", cur_a,  6'd38);
        check("rst_turn",   turn_a, 1'b0);
        check("rst_selv",   selv_a, 1'b0);
        check("rst_sel",    sel_a,  6'd0);
        check("rst_we",     we_a,   1'b0);
        check("rst_addr",   addr_a, 6'd0);
        check("rst_data",   data_a, 4'd0);
        check("rst_count",  cnt_a,  16'd0);
        check("rst_to",     to_a,   1'b0);
        check("rst_cur_b",  cur_b,  6'd38);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        check("start_to_select", st_a, 3'd1);

        // Full commit 38 -> 36
        set_square(38, 4'b0001);
        btn_c = 1'b1; tick(); tick();
        check("sel_state", st_a,   3'd2);
        check("sel_loc",   sel_a,  6'd38);
        check("sel_valid", selv_a, 1'b1);
        btn_c = 1'b0; tick(); tick();
        press(U);
        press(U);
        check("cursor_up2", cur_a, 6'd36);
        allow_move = 1'b1;
        btn_c = 1'b1; tick(); tick();
        check("place_state", st_a,   3'd3);
        check("place_we",    we_a,   1'b1);
        check("place_addr",  addr_a, 6'd36);
        check("place_data",  data_a, 4'b0001);
        btn_c = 1'b0; allow_move = 1'b0;
        tick();
        check("remove_state", st_a,   3'd4);
        check("remove_we",    we_a,   1'b1);
        check("remove_addr",  addr_a, 6'd38);
        check("remove_data",  data_a, 4'd0);
        check("remove_selv",  selv_a, 1'b0);
        tick();
        check("done_state", st_a,   3'd1);
        check("done_we",    we_a,   1'b0);
        check("done_turn",  turn_a, 1'b1);
        check("done_count", cnt_a,  16'd1);
        tick();

        // Held button moves once; L beats U
        reset_both();
        btn_l = 1'b1;
        repeat (10) tick();
        check("hold_l_once", cur_a, 6'd30);
        btn_l = 1'b0; tick(); tick();
        btn_l = 1'b1; btn_u = 1'b1; tick(); tick();
        check("prio_l_over_u", cur_a, 6'd22);
        btn_l = 1'b0; btn_u = 1'b0; tick(); tick();

        // Left edge: saturate vs wrap
        press(L); press(L);
        for (int i = 0; i < 6; i++) press(U);
        check("corner0_a", cur_a, 6'd0);
        check("corner0_b", cur_b, 6'd0);
        press(L);
        check("edge_l_sat",  cur_a, 6'd0);
        check("edge_l_wrap", cur_b, 6'd56);

        // Bottom-right edge
        reset_both();
        press(D);
        for (int i = 0; i < 3; i++) press(R);
        check("corner63_a", cur_a, 6'd63);
        check("corner63_b", cur_b, 6'd63);
        press(D);
        check("edge_d_sat",  cur_a, 6'd63);
        check("edge_d_wrap", cur_b, 6'd56);

        // Cancel, re-select, and reject opponent piece
        reset_both();
        board = '0;
        set_square(38, 4'b0001);
        set_square(46, 4'b0001);
        set_square(45, 4'b1001);
        press(C);
        check("cx_sel_state", st_a,  3'd2);
        check("cx_sel_loc",   sel_a, 6'd38);
        press(C);
        check("cancel_state", st_a,   3'd1);
        check("cancel_selv",  selv_a, 1'b0);
        check("cancel_we",    we_a,   1'b0);
        press(C);
        press(R);
        check("cursor_46", cur_a, 6'd46);
        press(C);
        check("resel_state", st_a,   3'd2);
        check("resel_loc",   sel_a,  6'd46);
        check("resel_selv",  selv_a, 1'b1);
        press(U);
        press(C);
        check("black_state", st_a,   3'd1);
        check("black_selv",  selv_a, 1'b0);

        // Turn timeout on the 100th SELECT cycle
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        repeat (100) tick();
        check("to_before", to_b,   1'b0);
        check("to_turn0",  turn_b, 1'b0);
        tick();
        check("to_pulse", to_b,   1'b1);
        check("to_turn1", turn_b, 1'b1);
        check("to_count", cnt_b,  16'd0);
        check("to_state", st_b,   3'd1);
        tick();
        check("to_end", to_b, 1'b0);

        // Reset during PLACE aborts the commit
        reset_both();
        board = '0;
        set_square(38, 4'b0001);
        press(C);
        press(U);
        allow_move = 1'b1;
        btn_c = 1'b1; tick(); tick();
        check("mid_place", st_a, 3'd3);
        rst_a = 1'b1; btn_c = 1'b0; allow_move = 1'b0;
        tick();
        check("mid_rst_we",    we_a,   1'b0);
        check("mid_rst_state", st_a,   3'd0);
        check("mid_rst_turn",  turn_a, 1'b0);
        check("mid_rst_count", cnt_a,  16'd0);
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_clear", we_a, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
